// File: rtl/buffer_arb_pkg.sv
// rtl/buffer_arb_pkg.sv - shared defaults and types for the transfer-buffer write arbiter
package buffer_arb_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_LEN_W  = 11;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_HOST,
    GRANT_STREAM
  } grant_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-request arbiter, round-robin by default, fixed stream priority under STREAM_FIXED_PRIORITY_EN
module rr_arbiter2
  import buffer_arb_pkg::*;
(
`ifndef STREAM_FIXED_PRIORITY_EN
  input  logic   clk,
  input  logic   reset,
`endif
  input  logic   stream_req,
  input  logic   host_req,
  output grant_t grant
);

`ifdef STREAM_FIXED_PRIORITY_EN
  // stream always wins a tie; no grant history is needed
  always_comb begin
    grant = GRANT_NONE;
    if (stream_req)    grant = GRANT_STREAM;
    else if (host_req) grant = GRANT_HOST;
  end
`else
  logic last_stream;

  // a tie goes to whichever side was not served most recently
  always_comb begin
    grant = GRANT_NONE;
    if (stream_req && host_req) grant = last_stream ? GRANT_HOST : GRANT_STREAM;
    else if (stream_req)        grant = GRANT_STREAM;
    else if (host_req)          grant = GRANT_HOST;
  end

  // history moves only on a real grant; reset marks stream as last so the host wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      last_stream <= 1'b1;
    end else if (grant != GRANT_NONE) begin
      last_stream <= (grant == GRANT_STREAM);
    end
  end
`endif

endmodule

// File: rtl/buffer_write_arbiter.sv
// rtl/buffer_write_arbiter.sv - shares the 8-bit buffer write port between a stream window and host writes (STREAM_FIXED_PRIORITY_EN: stream wins ties)
module buffer_write_arbiter
  import buffer_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              StreamStart,
  input  logic [ADDR_W-1:0] StreamStartAddr,
  input  logic [LEN_W-1:0]  StreamLen,
  input  logic              StreamValid,
  input  logic [7:0]        StreamData,
  output logic              StreamReady,
  output logic              StreamBusy,
  output logic              StreamDone,
  input  logic              HostWriteReq,
  input  logic [ADDR_W-1:0] HostAddr,
  input  logic [7:0]        HostData,
  output logic              HostAck,
  output logic              RamWriteEnable,
  output logic [ADDR_W-1:0] RamWriteAddr,
  output logic [7:0]        RamWriteData
);

  arb_state_t        state;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  remaining;
  grant_t            grant;
  logic              stream_req;
  logic              stream_gnt;
  logic              host_gnt;

  // a start pulse claims the stream side for its cycle, so no byte is taken while reloading
  assign stream_req = (state == ST_ACTIVE) && StreamValid && !StreamStart;

  rr_arbiter2 u_arb (
`ifndef STREAM_FIXED_PRIORITY_EN
    .clk        (Clk),
    .reset      (Reset),
`endif
    .stream_req (stream_req),
    .host_req   (HostWriteReq),
    .grant      (grant)
  );

  assign stream_gnt  = (grant == GRANT_STREAM);
  assign host_gnt    = (grant == GRANT_HOST);
  assign StreamReady = stream_gnt;
  assign HostAck     = host_gnt;
  assign StreamBusy  = (state == ST_ACTIVE);

  // window sequencing plus the registered RAM write port, one cycle behind the grant
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      remaining      <= '0;
      StreamDone     <= 1'b0;
      RamWriteEnable <= 1'b0;
      RamWriteAddr   <= '0;
      RamWriteData   <= '0;
    end else begin
      StreamDone     <= 1'b0;
      RamWriteEnable <= stream_gnt || host_gnt;

      if (host_gnt) begin
        RamWriteAddr <= HostAddr;
        RamWriteData <= HostData;
      end else if (stream_gnt) begin
        RamWriteAddr <= ptr;
        RamWriteData <= StreamData;
      end

      if (StreamStart) begin
        ptr       <= StreamStartAddr;
        remaining <= StreamLen;
        if (StreamLen == '0) begin
          state      <= ST_IDLE;
          StreamDone <= 1'b1;
        end else begin
          state <= ST_ACTIVE;
        end
      end else if (stream_gnt) begin
        ptr       <= ptr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
        if (remaining == LEN_W'(1)) begin
          state      <= ST_IDLE;
          StreamDone <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/buffer_write_arbiter.md
Name: buffer_write_arbiter

Overview:
- Owns the single 8-bit write port of the 1 KiB transfer buffer (16-bit read side elsewhere).
- Shares the port between two requesters:
  - a streaming source, e.g. SPI RX bytes, which auto-increments through a programmed address window;
  - a random-access host source, e.g. cart-bus byte writes.
- Sequences the stream window, grants at most one write per cycle, and registers the RAM write strobe, address and data.

Parameters:
- ADDR_W, 10, buffer byte-address width; buffer depth is 2**ADDR_W.
- LEN_W, 11, stream length width; must hold 2**ADDR_W.

Ports:
- Clk  in  1  buffer write clock; all logic is posedge.
- Reset  in  1  synchronous, active-high.
- StreamStart  in  1  one-cycle pulse; loads StreamStartAddr/StreamLen and begins a window.
- StreamStartAddr  in  ADDR_W  first byte address of the window.
- StreamLen  in  LEN_W  byte count, 0..2**ADDR_W.
- StreamValid  in  1  stream byte available.
- StreamData  in  8  stream byte.
- StreamReady  out  1  stream byte accepted this cycle (combinational).
- StreamBusy  out  1  window active.
- StreamDone  out  1  one-cycle pulse when the window completes.
- HostWriteReq  in  1  host write request, held until acked.
- HostAddr  in  ADDR_W  host byte address.
- HostData  in  8  host byte.
- HostAck  out  1  host write accepted this cycle (combinational).
- RamWriteEnable  out  1  to buffer WriteEnable.
- RamWriteAddr  out  ADDR_W  to buffer WriteAddr.
- RamWriteData  out  8  to buffer WriteData.

Behaviour:
- Reset values:
  - StreamBusy=0, StreamDone=0, RamWriteEnable=0, RamWriteAddr=0, RamWriteData=0.
  - Internal pointer=0, remaining=0, state IDLE, last-grant=STREAM, so the host wins the first tie.
  - Reset mid-window abandons the window with no Done pulse.
- States:
  - IDLE -> ACTIVE on StreamStart with StreamLen!=0.
  - ACTIVE -> IDLE when the last byte is accepted; StreamDone pulses in the following cycle.
  - StreamStart with StreamLen=0: stays IDLE, StreamDone pulses next cycle, no writes.
- Stream request = StreamBusy && StreamValid.
- Host request = HostWriteReq.
- Arbitration (round-robin):
  - Only one requester: it wins.
  - Both request: the one not granted last wins.
  - last-grant updates only on an actual grant.
- StreamReady = stream granted. HostAck = host granted. Neither depends on the other's ack.
- On a grant: next cycle RamWriteEnable=1, with RamWriteAddr/RamWriteData taken from the winner. Latency is exactly 1 cycle; otherwise RamWriteEnable=0.
- Address and count handling:
  - Each accepted stream byte increments the pointer modulo 2**ADDR_W and decrements remaining.
  - A window that runs past 1023 wraps to 0.
- StreamStart while ACTIVE:
  - Aborts the current window and reloads the new parameters; no Done pulse for the aborted window.
  - In that cycle StreamReady=0, so no stream byte is accepted.
  - A host grant in the same cycle proceeds normally.
- StreamStart in the same cycle the last byte would be accepted: the start takes priority (the byte is not accepted).
- Host writes to addresses inside an active window are permitted and not checked.

Optional Feature:
- Macro STREAM_FIXED_PRIORITY_EN.
- Defined: the stream always wins ties, and the last-grant register is removed. The host can starve while a stream is valid every cycle.
- Undefined: round-robin as above.

Decomposition:
- Package buffer_arb_pkg holds:
  - ADDR_W/LEN_W defaults;
  - typedef grant_t {GRANT_NONE, GRANT_HOST, GRANT_STREAM};
  - typedef arb_state_t {ST_IDLE, ST_ACTIVE}.
- One sub-module, rr_arbiter2: two-request round-robin arbiter with the fixed-priority variant under the macro. It is combinational grant plus the last-grant register.

Test Plan:
- Reset, then StreamStart addr=0x010 len=4, StreamValid constant, bytes A0..A3 -> RamWriteEnable on 4 consecutive cycles at 0x010..0x013 one cycle after each StreamReady; StreamDone one cycle after the last accept; StreamBusy=0 afterwards.
- Wrap: addr=0x3FE len=4 -> writes at 0x3FE, 0x3FF, 0x000, 0x001.
- Contention: active stream with Valid held, HostWriteReq held with addr=0x200 data=0x55 -> first tie grants host, then alternating stream/host/stream; exactly one RamWriteEnable per cycle; host write lands at 0x200=0x55. With STREAM_FIXED_PRIORITY_EN, the host is acked only after the window ends.
- Restart: start len=8, accept 3 bytes, StreamStart addr=0x100 len=2 -> no Done for the first window; next writes at 0x100, 0x101; single Done pulse.
- len=0 start -> StreamDone pulse next cycle, StreamBusy never 1, no RAM writes.
- Reset asserted mid-window after 2 bytes -> all outputs 0 next cycle, no Done; a subsequent start behaves as from power-up.
